// File: rtl/video_stream_source.sv
// Frame reader for bring-up: fetches a framebuffer through a burst read port into
// a local FIFO and replays it as an AXI4-Stream video stream with tuser/tlast framing.
module video_stream_source #(
    parameter int FIFO_DEPTH = 64,
    parameter int BURST      = 16
) (
    input  logic        m_axis_vid_aclk,
    input  logic        aresetn,
    input  logic [31:0] cfg_base,
    input  logic [11:0] cfg_words,
    input  logic [11:0] cfg_lines,
    input  logic [15:0] cfg_stride,
    input  logic        cfg_enable,
    input  logic        frame_start_req,
    output logic        busy,
    output logic        frame_done,
    output logic        mem_rd_req,
    output logic [31:0] mem_rd_addr,
    output logic [7:0]  mem_rd_len,
    input  logic        mem_rd_ack,
    input  logic        mem_rd_valid,
    input  logic [31:0] mem_rd_data,
    output logic [31:0] m_axis_vid_tdata,
    output logic        m_axis_vid_tvalid,
    input  logic        m_axis_vid_tready,
    output logic        m_axis_vid_tlast,
    output logic        m_axis_vid_tuser
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(FIFO_DEPTH + 1);

    typedef enum logic [2:0] {S_IDLE, S_REQ, S_ACK, S_DRAIN, S_ABORT} state_t;

    state_t      r_state;
    state_t      w_nextState;

    logic [11:0] r_words;
    logic [11:0] r_lines;
    logic [15:0] r_stride;
    logic [31:0] r_lineAddr;
    logic [11:0] r_wordIdx;
    logic [11:0] r_line;
    logic [8:0]  r_burstWords;
    logic        r_req;
    logic [31:0] r_addr;
    logic [7:0]  r_len;
    logic        r_frameDone;
    logic [CW-1:0] r_count;
    logic [CW-1:0] r_outstanding;
    logic [AW-1:0] r_wrPtr;
    logic [AW-1:0] r_rdPtr;
    logic [31:0] r_mem [FIFO_DEPTH];
    logic [11:0] r_outX;
    logic [11:0] r_outY;

    logic [11:0] w_remain;
    logic [8:0]  w_burstLen;
    logic [CW:0] w_used;
    logic [CW:0] w_free;
    logic        w_fits;
    logic        w_start;
    logic        w_abort;
    logic        w_issue;
    logic        w_ackFire;
    logic [12:0] w_wordEnd;
    logic        w_lineDone;
    logic        w_lastBurst;
    logic        w_rdAccept;
    logic        w_flush;
    logic        w_push;
    logic        w_tvalid;
    logic        w_pop;
    logic        w_lastX;
    logic        w_frameEnd;

    // Bursts are clipped to the end of the current line so they never straddle a stride gap.
    assign w_remain    = r_words - r_wordIdx;
    assign w_burstLen  = (w_remain >= 12'(BURST)) ? 9'(BURST) : w_remain[8:0];
    assign w_used      = {1'b0, r_count} + {1'b0, r_outstanding};
    assign w_free      = (CW+1)'(FIFO_DEPTH) - w_used;
    assign w_fits      = 32'(w_free) >= 32'(w_burstLen);

    assign w_start     = (r_state == S_IDLE) && frame_start_req && cfg_enable &&
                         (cfg_words != 12'd0) && (cfg_lines != 12'd0);
    assign w_abort     = !cfg_enable &&
                         ((r_state == S_REQ) || (r_state == S_ACK) || (r_state == S_DRAIN));
    assign w_issue     = (r_state == S_REQ) && !w_abort && w_fits;
    assign w_ackFire   = (r_state == S_ACK) && r_req && mem_rd_ack;
    assign w_wordEnd   = {1'b0, r_wordIdx} + {4'b0, r_burstWords};
    assign w_lineDone  = (w_wordEnd == {1'b0, r_words});
    assign w_lastBurst = w_lineDone && (r_line == r_lines - 12'd1);

    // Data arriving during an abort still retires outstanding words but is never stored.
    assign w_rdAccept  = mem_rd_valid && (r_outstanding != '0);
    assign w_flush     = w_abort || (r_state == S_ABORT);
    assign w_push      = w_rdAccept && !w_flush;
    assign w_tvalid    = (r_count != '0);
    assign w_pop       = w_tvalid && m_axis_vid_tready && !w_abort;
    assign w_lastX     = (r_outX == r_words - 12'd1);
    assign w_frameEnd  = w_pop && w_lastX && (r_outY == r_lines - 12'd1);

    always_ff @(posedge m_axis_vid_aclk) begin
        if (!aresetn) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState = r_state;
        case (r_state)
            S_IDLE:  if (w_start) w_nextState = S_REQ;
            S_REQ: begin
                if (w_abort)     w_nextState = S_ABORT;
                else if (w_fits) w_nextState = S_ACK;
            end
            S_ACK: begin
                if (w_abort)         w_nextState = S_ABORT;
                else if (w_ackFire)  w_nextState = w_lastBurst ? S_DRAIN : S_REQ;
            end
            S_DRAIN: begin
                if (w_abort)          w_nextState = S_ABORT;
                else if (r_frameDone) w_nextState = S_IDLE;
            end
            S_ABORT: if (r_outstanding == '0) w_nextState = S_IDLE;
            default: w_nextState = S_IDLE;
        endcase
    end

    always_ff @(posedge m_axis_vid_aclk) begin
        if (!aresetn) begin
            r_words       <= '0;
            r_lines       <= '0;
            r_stride      <= '0;
            r_lineAddr    <= '0;
            r_wordIdx     <= '0;
            r_line        <= '0;
            r_burstWords  <= '0;
            r_req         <= 1'b0;
            r_addr        <= '0;
            r_len         <= '0;
            r_frameDone   <= 1'b0;
            r_count       <= '0;
            r_outstanding <= '0;
            r_wrPtr       <= '0;
            r_rdPtr       <= '0;
            r_outX        <= '0;
            r_outY        <= '0;
        end else begin
            if (w_start) begin
                r_words    <= cfg_words;
                r_lines    <= cfg_lines;
                r_stride   <= cfg_stride;
                r_lineAddr <= cfg_base;
                r_wordIdx  <= '0;
                r_line     <= '0;
            end
            if (w_issue) begin
                r_req        <= 1'b1;
                r_addr       <= r_lineAddr + {18'b0, r_wordIdx, 2'b00};
                r_len        <= 8'(w_burstLen - 9'd1);
                r_burstWords <= w_burstLen;
            end
            if (w_ackFire) begin
                r_req <= 1'b0;
                if (w_lineDone) begin
                    r_wordIdx  <= '0;
                    r_line     <= r_line + 12'd1;
                    r_lineAddr <= r_lineAddr + {16'b0, r_stride};
                end else begin
                    r_wordIdx  <= w_wordEnd[11:0];
                end
            end
            if (w_abort) begin
                r_req <= 1'b0;
            end

            r_outstanding <= r_outstanding
                             + (w_ackFire  ? CW'(r_burstWords) : CW'(0))
                             - (w_rdAccept ? CW'(1) : CW'(0));
            r_frameDone   <= w_frameEnd;

            if (w_flush) begin
                r_count <= '0;
                r_wrPtr <= '0;
                r_rdPtr <= '0;
            end else begin
                r_count <= r_count + CW'(w_push) - CW'(w_pop);
                if (w_push) r_wrPtr <= r_wrPtr + AW'(1);
                if (w_pop)  r_rdPtr <= r_rdPtr + AW'(1);
            end

            // Output position restarts with every frame so a resumed stream leads with tuser.
            if (w_flush || w_start) begin
                r_outX <= '0;
                r_outY <= '0;
            end else if (w_pop) begin
                if (w_lastX) begin
                    r_outX <= '0;
                    r_outY <= r_outY + 12'd1;
                end else begin
                    r_outX <= r_outX + 12'd1;
                end
            end
        end
    end

    always_ff @(posedge m_axis_vid_aclk) begin
        if (w_push) begin
            r_mem[r_wrPtr] <= mem_rd_data;
        end
    end

    assign busy              = (r_state != S_IDLE);
    assign frame_done        = r_frameDone;
    assign mem_rd_req        = r_req;
    assign mem_rd_addr       = r_addr;
    assign mem_rd_len        = r_len;
    assign m_axis_vid_tvalid = w_tvalid;
    assign m_axis_vid_tdata  = w_tvalid ? r_mem[r_rdPtr] : 32'd0;
    assign m_axis_vid_tlast  = w_tvalid && w_lastX;
    assign m_axis_vid_tuser  = w_tvalid && (r_outX == 12'd0) && (r_outY == 12'd0);

endmodule

// File: tb/tb_video_stream_source.sv
// Bench for video_stream_source: a burst memory model answers reads with address-valued
// data, and a scoreboard of expected beats is checked against the AXIS output.
module tb_video_stream_source;

    localparam int FIFO_DEPTH = 32;
    localparam int BURST      = 16;

    logic        m_axis_vid_aclk = 1'b0;
    logic        aresetn;
    logic [31:0] cfg_base;
    logic [11:0] cfg_words;
    logic [11:0] cfg_lines;
    logic [15:0] cfg_stride;
    logic        cfg_enable;
    logic        frame_start_req;
    logic        busy;
    logic        frame_done;
    logic        mem_rd_req;
    logic [31:0] mem_rd_addr;
    logic [7:0]  mem_rd_len;
    logic        mem_rd_ack;
    logic        mem_rd_valid;
    logic [31:0] mem_rd_data;
    logic [31:0] m_axis_vid_tdata;
    logic        m_axis_vid_tvalid;
    logic        m_axis_vid_tready;
    logic        m_axis_vid_tlast;
    logic        m_axis_vid_tuser;

    typedef struct {
        logic [31:0] data;
        logic        last;
        logic        user;
        logic        frameEnd;
    } beat_t;

    typedef struct {
        logic [31:0] addr;
        logic [7:0]  len;
    } req_t;

    beat_t       sbQ[$];
    req_t        reqLog[$];
    logic [31:0] dataQ[$];

    int   checkCount     = 0;
    int   passCount      = 0;
    int   beatCount      = 0;
    int   deliveredCount = 0;
    int   ackBudget      = 1000000;
    int   readyMode      = 1;
    logic dataHold       = 1'b0;
    logic spurValid      = 1'b0;
    logic doneExpected   = 1'b0;

    video_stream_source #(
        .FIFO_DEPTH(FIFO_DEPTH),
        .BURST     (BURST)
    ) dut (
        .m_axis_vid_aclk  (m_axis_vid_aclk),
        .aresetn          (aresetn),
        .cfg_base         (cfg_base),
        .cfg_words        (cfg_words),
        .cfg_lines        (cfg_lines),
        .cfg_stride       (cfg_stride),
        .cfg_enable       (cfg_enable),
        .frame_start_req  (frame_start_req),
        .busy             (busy),
        .frame_done       (frame_done),
        .mem_rd_req       (mem_rd_req),
        .mem_rd_addr      (mem_rd_addr),
        .mem_rd_len       (mem_rd_len),
        .mem_rd_ack       (mem_rd_ack),
        .mem_rd_valid     (mem_rd_valid),
        .mem_rd_data      (mem_rd_data),
        .m_axis_vid_tdata (m_axis_vid_tdata),
        .m_axis_vid_tvalid(m_axis_vid_tvalid),
        .m_axis_vid_tready(m_axis_vid_tready),
        .m_axis_vid_tlast (m_axis_vid_tlast),
        .m_axis_vid_tuser (m_axis_vid_tuser)
    );

    always #5 m_axis_vid_aclk = ~m_axis_vid_aclk;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual === expected) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, actual, expected, $time);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge m_axis_vid_aclk);
            #1;
        end
    endtask

    task automatic applyStimulus(input logic [31:0] base, input logic [11:0] words,
                                 input logic [11:0] lines, input logic [15:0] stride,
                                 input bit expectBeats);
        beat_t b;
        if (expectBeats) begin
            for (int y = 0; y < int'(lines); y++) begin
                for (int x = 0; x < int'(words); x++) begin
                    b.data     = base + 32'(y) * {16'b0, stride} + 32'(x * 4);
                    b.last     = (x == int'(words) - 1);
                    b.user     = (x == 0) && (y == 0);
                    b.frameEnd = (x == int'(words) - 1) && (y == int'(lines) - 1);
                    sbQ.push_back(b);
                end
            end
        end
        cfg_base        = base;
        cfg_words       = words;
        cfg_lines       = lines;
        cfg_stride      = stride;
        frame_start_req = 1'b1;
        tick();
        frame_start_req = 1'b0;
    endtask

    task automatic waitIdle(input int budget, input string tag);
        int n = 0;
        do begin
            @(negedge m_axis_vid_aclk);
            n++;
        end while (busy && n < budget);
        checkOutput({tag, "_idle"}, 32'(busy), 32'd0);
        checkOutput({tag, "_sb_drained"}, 32'(sbQ.size()), 32'd0);
        tick();
    endtask

    // Memory model: one-cycle ack, data streamed one word per cycle starting the cycle after ack.
    initial begin
        mem_rd_ack   = 1'b0;
        mem_rd_valid = 1'b0;
        mem_rd_data  = 32'd0;
        forever begin
            @(posedge m_axis_vid_aclk);
            #2;
            if (mem_rd_ack && reqLog.size() > 0) begin
                for (int i = 0; i <= int'(reqLog[reqLog.size()-1].len); i++) begin
                    dataQ.push_back(reqLog[reqLog.size()-1].addr + 32'(i * 4));
                end
            end
            if (mem_rd_req && !mem_rd_ack && ackBudget > 0) begin
                mem_rd_ack = 1'b1;
                ackBudget--;
                reqLog.push_back('{addr: mem_rd_addr, len: mem_rd_len});
            end else begin
                mem_rd_ack = 1'b0;
            end
            if (spurValid) begin
                mem_rd_valid = 1'b1;
                mem_rd_data  = 32'hDEAD_BEEF;
            end else if (dataQ.size() > 0 && !dataHold) begin
                mem_rd_valid = 1'b1;
                mem_rd_data  = dataQ.pop_front();
                deliveredCount++;
            end else begin
                mem_rd_valid = 1'b0;
            end
        end
    end

    initial begin
        m_axis_vid_tready = 1'b0;
        forever begin
            @(posedge m_axis_vid_aclk);
            #2;
            case (readyMode)
                0:       m_axis_vid_tready = 1'b0;
                1:       m_axis_vid_tready = 1'b1;
                default: m_axis_vid_tready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // Output monitor: scoreboard compare per beat, stall stability, frame_done timing.
    initial begin
        beat_t       e;
        logic        prevStall = 1'b0;
        logic [31:0] prevData  = 32'd0;
        logic        prevLast  = 1'b0;
        logic        prevUser  = 1'b0;
        forever begin
            @(negedge m_axis_vid_aclk);
            if (doneExpected) begin
                checkOutput("frame_done", 32'(frame_done), 32'd1);
                checkOutput("busy_at_done", 32'(busy), 32'd1);
                doneExpected = 1'b0;
            end else if (frame_done) begin
                checkOutput("frame_done_spurious", 32'(frame_done), 32'd0);
            end
            if (prevStall && m_axis_vid_tvalid) begin
                checkOutput("stall_tdata", m_axis_vid_tdata, prevData);
                checkOutput("stall_tlast", 32'(m_axis_vid_tlast), 32'(prevLast));
                checkOutput("stall_tuser", 32'(m_axis_vid_tuser), 32'(prevUser));
            end
            prevStall = m_axis_vid_tvalid && !m_axis_vid_tready;
            prevData  = m_axis_vid_tdata;
            prevLast  = m_axis_vid_tlast;
            prevUser  = m_axis_vid_tuser;
            if (m_axis_vid_tvalid && m_axis_vid_tready) begin
                beatCount++;
                if (sbQ.size() == 0) begin
                    checkOutput("unexpected_beat_tvalid", 32'(m_axis_vid_tvalid), 32'd0);
                end else begin
                    e = sbQ.pop_front();
                    checkOutput("tdata", m_axis_vid_tdata, e.data);
                    checkOutput("tlast", 32'(m_axis_vid_tlast), 32'(e.last));
                    checkOutput("tuser", 32'(m_axis_vid_tuser), 32'(e.user));
                    if (e.frameEnd) doneExpected = 1'b1;
                end
            end
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish, %0d/%0d checks passed", passCount, checkCount);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int beatBase;
        int deliveredBase;
        int n;

        aresetn         = 1'b0;
        cfg_base        = 32'd0;
        cfg_words       = 12'd0;
        cfg_lines       = 12'd0;
        cfg_stride      = 16'd0;
        cfg_enable      = 1'b1;
        frame_start_req = 1'b0;
        tick(3);
        @(negedge m_axis_vid_aclk);
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_frame_done", 32'(frame_done), 32'd0);
        checkOutput("rst_req", 32'(mem_rd_req), 32'd0);
        checkOutput("rst_addr", mem_rd_addr, 32'd0);
        checkOutput("rst_len", 32'(mem_rd_len), 32'd0);
        checkOutput("rst_tvalid", 32'(m_axis_vid_tvalid), 32'd0);
        checkOutput("rst_tdata", m_axis_vid_tdata, 32'd0);
        checkOutput("rst_tlast", 32'(m_axis_vid_tlast), 32'd0);
        checkOutput("rst_tuser", 32'(m_axis_vid_tuser), 32'd0);
        tick();
        aresetn = 1'b1;
        tick(2);

        $display("[TB] two lines of four words");
        readyMode = 1;
        reqLog.delete();
        beatBase = beatCount;
        applyStimulus(32'h1000, 12'd4, 12'd2, 16'h100, 1'b1);
        @(negedge m_axis_vid_aclk);
        checkOutput("t1_busy_after_start", 32'(busy), 32'd1);
        waitIdle(200, "t1");
        checkOutput("t1_req_count", 32'(reqLog.size()), 32'd2);
        if (reqLog.size() == 2) begin
            checkOutput("t1_req0_addr", reqLog[0].addr, 32'h1000);
            checkOutput("t1_req0_len", 32'(reqLog[0].len), 32'd3);
            checkOutput("t1_req1_addr", reqLog[1].addr, 32'h1100);
            checkOutput("t1_req1_len", 32'(reqLog[1].len), 32'd3);
        end
        checkOutput("t1_beats", 32'(beatCount - beatBase), 32'd8);

        $display("[TB] one line of twenty words split into bursts");
        reqLog.delete();
        beatBase = beatCount;
        applyStimulus(32'h2000, 12'd20, 12'd1, 16'h80, 1'b1);
        waitIdle(200, "t2");
        checkOutput("t2_req_count", 32'(reqLog.size()), 32'd2);
        if (reqLog.size() == 2) begin
            checkOutput("t2_req0_addr", reqLog[0].addr, 32'h2000);
            checkOutput("t2_req0_len", 32'(reqLog[0].len), 32'd15);
            checkOutput("t2_req1_addr", reqLog[1].addr, 32'h2040);
            checkOutput("t2_req1_len", 32'(reqLog[1].len), 32'd3);
        end
        checkOutput("t2_beats", 32'(beatCount - beatBase), 32'd20);

        $display("[TB] backpressure limits fetch to the FIFO size");
        readyMode = 0;
        tick(2);
        reqLog.delete();
        beatBase = beatCount;
        applyStimulus(32'h4000, 12'd64, 12'd1, 16'h0, 1'b1);
        tick(100);
        @(negedge m_axis_vid_aclk);
        checkOutput("t3_req_count_stalled", 32'(reqLog.size()), 32'd2);
        checkOutput("t3_req_low_stalled", 32'(mem_rd_req), 32'd0);
        checkOutput("t3_tvalid_stalled", 32'(m_axis_vid_tvalid), 32'd1);
        checkOutput("t3_head_data", m_axis_vid_tdata, 32'h4000);
        tick();
        readyMode = 1;
        waitIdle(500, "t3");
        checkOutput("t3_req_count", 32'(reqLog.size()), 32'd4);
        checkOutput("t3_beats", 32'(beatCount - beatBase), 32'd64);

        $display("[TB] random tready, start held through frame_done");
        readyMode = 2;
        reqLog.delete();
        beatBase = beatCount;
        applyStimulus(32'h8000, 12'd6, 12'd3, 16'h40, 1'b1);
        frame_start_req = 1'b1;
        n = 0;
        do begin
            @(negedge m_axis_vid_aclk);
            n++;
        end while (!frame_done && n < 2000);
        checkOutput("t4_done_seen", 32'(frame_done), 32'd1);
        tick();
        frame_start_req = 1'b0;
        tick(5);
        @(negedge m_axis_vid_aclk);
        checkOutput("t4_restart_ignored", 32'(busy), 32'd0);
        checkOutput("t4_req_count", 32'(reqLog.size()), 32'd3);
        checkOutput("t4_beats", 32'(beatCount - beatBase), 32'd18);
        checkOutput("t4_sb_drained", 32'(sbQ.size()), 32'd0);
        tick();

        $display("[TB] abort with eight words outstanding");
        readyMode = 1;
        ackBudget = 1;
        dataHold  = 1'b1;
        reqLog.delete();
        applyStimulus(32'hA000, 12'd8, 12'd2, 16'h100, 1'b0);
        n = 0;
        do begin
            @(negedge m_axis_vid_aclk);
            n++;
        end while (!(reqLog.size() == 1 && mem_rd_req) && n < 100);
        checkOutput("t5_second_req_pending", 32'(mem_rd_req), 32'd1);
        tick();
        cfg_enable = 1'b0;
        tick();
        @(negedge m_axis_vid_aclk);
        checkOutput("t5_req_dropped", 32'(mem_rd_req), 32'd0);
        checkOutput("t5_tvalid_dropped", 32'(m_axis_vid_tvalid), 32'd0);
        checkOutput("t5_busy_holding", 32'(busy), 32'd1);
        tick(5);
        @(negedge m_axis_vid_aclk);
        checkOutput("t5_req_still_low", 32'(mem_rd_req), 32'd0);
        checkOutput("t5_busy_waiting_data", 32'(busy), 32'd1);
        tick();
        deliveredBase = deliveredCount;
        dataHold      = 1'b0;
        n = 0;
        do begin
            @(negedge m_axis_vid_aclk);
            n++;
        end while (deliveredCount - deliveredBase < 8 && n < 100);
        checkOutput("t5_delivered", 32'(deliveredCount - deliveredBase), 32'd8);
        checkOutput("t5_busy_at_last_valid", 32'(busy), 32'd1);
        tick();
        waitIdle(50, "t5");
        checkOutput("t5_req_count", 32'(reqLog.size()), 32'd1);
        checkOutput("t5_tvalid_after", 32'(m_axis_vid_tvalid), 32'd0);
        cfg_enable = 1'b1;
        ackBudget  = 1000000;
        tick(2);

        $display("[TB] restart after abort");
        reqLog.delete();
        beatBase = beatCount;
        applyStimulus(32'hC000, 12'd4, 12'd1, 16'h10, 1'b1);
        waitIdle(200, "t6");
        checkOutput("t6_beats", 32'(beatCount - beatBase), 32'd4);
        checkOutput("t6_req_count", 32'(reqLog.size()), 32'd1);

        $display("[TB] starts that must be ignored");
        reqLog.delete();
        applyStimulus(32'hE000, 12'd0, 12'd2, 16'h10, 1'b0);
        tick(10);
        @(negedge m_axis_vid_aclk);
        checkOutput("t7_words0_busy", 32'(busy), 32'd0);
        checkOutput("t7_words0_req", 32'(reqLog.size()), 32'd0);
        tick();
        applyStimulus(32'hE000, 12'd4, 12'd0, 16'h10, 1'b0);
        tick(10);
        @(negedge m_axis_vid_aclk);
        checkOutput("t7_lines0_busy", 32'(busy), 32'd0);
        tick();
        cfg_enable = 1'b0;
        applyStimulus(32'hE000, 12'd4, 12'd1, 16'h10, 1'b0);
        tick(10);
        @(negedge m_axis_vid_aclk);
        checkOutput("t7_disabled_busy", 32'(busy), 32'd0);
        checkOutput("t7_req_total", 32'(reqLog.size()), 32'd0);
        tick();
        cfg_enable = 1'b1;

        $display("[TB] stray read data while idle");
        spurValid = 1'b1;
        tick();
        spurValid = 1'b0;
        tick(3);
        @(negedge m_axis_vid_aclk);
        checkOutput("t8_spur_tvalid", 32'(m_axis_vid_tvalid), 32'd0);
        checkOutput("t8_spur_busy", 32'(busy), 32'd0);
        tick(3);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
